// File: rtl/dmem_lsu_seq_pkg.sv
// Shared definitions for the vector load/store sequencer.
// Holds the default memory depth and beat limit, the address / register /
// count / data widths, and the sequencer state encoding.
package dmem_lsu_seq_pkg;

  localparam int DEPTH_DEF = 129;  // data-memory words
  localparam int MAXB_DEF  = 8;    // maximum beats per request
  localparam int AW        = 8;    // word-address width
  localparam int RW        = 3;    // vector register index width
  localparam int CW        = 4;    // beat count width
  localparam int DW        = 128;  // data word width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lsu_seq_addr_gen.sv
// lsu_addr_gen: per-request address / register sequencing.
// Latches base, stride, beat count and first register on load, then on each
// step advances to the next beat.
//   clk, rst      : clock, synchronous active-low reset
//   load          : latch a new request and restart at beat 0
//   step          : advance to the next beat
//   base, stride  : first word address and per-beat increment
//   count         : beats in the request
//   reg_base      : first vector register index
//   addr          : current beat address, (base + k*stride) mod 256
//   reg_idx       : current beat register, (reg_base + k) mod 8
//   in_range      : current address is below DEPTH
//   last_beat     : current beat is the final one of the request
module lsu_addr_gen
  import dmem_lsu_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] stride,
  input  logic [CW-1:0] count,
  input  logic [RW-1:0] reg_base,
  output logic [AW-1:0] addr,
  output logic [RW-1:0] reg_idx,
  output logic          in_range,
  output logic          last_beat
);

  localparam logic [31:0] DEPTH_W = DEPTH;

  logic [AW-1:0] base_q;
  logic [AW-1:0] stride_q;
  logic [AW-1:0] off_q;     // running k*stride, wraps at 256
  logic [CW-1:0] count_q;
  logic [CW-1:0] beat_q;
  logic [RW-1:0] reg_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q   <= '0;
      stride_q <= '0;
      off_q    <= '0;
      count_q  <= '0;
      beat_q   <= '0;
      reg_q    <= '0;
    end else if (load) begin
      base_q   <= base;
      stride_q <= stride;
      off_q    <= '0;
      count_q  <= count;
      beat_q   <= '0;
      reg_q    <= reg_base;
    end else if (step) begin
      off_q  <= off_q + stride_q;
      beat_q <= beat_q + CW'(1);
    end
  end

  // 8-bit adds: carries out of the top bit are dropped by design.
  assign addr      = base_q + off_q;
  assign reg_idx   = reg_q + beat_q[RW-1:0];
  assign in_range  = 32'(addr) < DEPTH_W;
  assign last_beat = beat_q == (count_q - CW'(1));

endmodule

// File: rtl/dmem_lsu_seq.sv
// dmem_lsu_seq: sequences multi-beat vector loads and stores between a
// 128-bit data memory and an 8-entry vector register file, one beat per cycle.
//   clk, rst                    : clock, synchronous active-low reset
//   req_valid / req_ready       : request handshake (accepted only in IDLE)
//   req_store                   : 1 = store (regfile -> memory), 0 = load
//   req_base, req_stride        : first word address, per-beat increment
//   req_count                   : beats, 0..MAXB legal
//   req_reg                     : first vector register
//   mem_addr/wdata/we/re, rdata : data-memory port (rdata combinational)
//   rf_raddr/rdata              : regfile read port (combinational)
//   rf_waddr/wdata/we           : regfile write port
//   done, err                   : one-cycle completion pulse, fault flag
module dmem_lsu_seq
  import dmem_lsu_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int MAXB  = MAXB_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic [AW-1:0] req_base,
  input  logic [AW-1:0] req_stride,
  input  logic [CW-1:0] req_count,
  input  logic [RW-1:0] req_reg,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic [RW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic [RW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_we,
  output logic          done,
  output logic          err
);

  localparam logic [CW-1:0] MAXB_W = CW'(MAXB);

  state_t        state_q, state_d;
  logic          fault_q;
  logic          store_q;
  logic          accept;
  logic          bad_count;
  logic [AW-1:0] beat_addr;
  logic [RW-1:0] beat_reg;
  logic          in_range;
  logic          last_beat;

  assign accept    = (state_q == IDLE) && req_valid;
  assign bad_count = req_count > MAXB_W;

  lsu_addr_gen #(.DEPTH(DEPTH)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (state_q == RUN),
    .base      (req_base),
    .stride    (req_stride),
    .count     (req_count),
    .reg_base  (req_reg),
    .addr      (beat_addr),
    .reg_idx   (beat_reg),
    .in_range  (in_range),
    .last_beat (last_beat)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (req_count == '0 || bad_count) ? DONE : RUN;
      RUN:  if (last_beat) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An over-limit count is recorded as a fault at accept time, so err in
  // DONE is simply the sticky bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fault_q <= 1'b0;
      store_q <= 1'b0;
    end else if (accept) begin
      fault_q <= bad_count;
      store_q <= req_store;
    end else if (state_q == RUN && !in_range) begin
      fault_q <= 1'b1;
    end
  end

  // Strobes are qualified with rst so an asserted reset kills a beat in the
  // same cycle rather than at the next edge.
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    rf_raddr  = '0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    rf_we     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      RUN: begin
        mem_addr = DW'(beat_addr);
        if (store_q) begin
          rf_raddr  = beat_reg;
          mem_wdata = rf_rdata;
          mem_we    = in_range && rst;
        end else begin
          rf_waddr = beat_reg;
          rf_wdata = mem_rdata;
          mem_re   = in_range && rst;
          rf_we    = in_range && rst;
        end
      end
      DONE: begin
        done = rst;
        err  = fault_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu_seq.sv
module tb_dmem_lsu_seq;
  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_store;
  logic [7:0]   req_base, req_stride;
  logic [3:0]   req_count;
  logic [2:0]   req_reg;
  logic [127:0] mem_addr, mem_wdata, mem_rdata;
  logic         mem_we, mem_re;
  logic [2:0]   rf_raddr, rf_waddr;
  logic [127:0] rf_rdata, rf_wdata;
  logic         rf_we, done, err;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // Memory word at address a and register r contents, distinct per location.
  function automatic logic [127:0] mem_pat(input logic [7:0] a);
    return {16{a ^ 8'h5A}};
  endfunction
  function automatic logic [127:0] rf_pat(input logic [2:0] r);
    return {32{1'b1, r}};
  endfunction

  assign mem_rdata = mem_re ? mem_pat(mem_addr[7:0]) : '0;
  assign rf_rdata  = rf_pat(rf_raddr);

  dmem_lsu_seq #(.DEPTH(129), .MAXB(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_base(req_base), .req_stride(req_stride),
    .req_count(req_count), .req_reg(req_reg), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we),
    .done(done), .err(err)
  );

  // Drives one request for one cycle; returns at the negedge after accept.
  task automatic issue(input logic st, input logic [7:0] b, input logic [7:0] s,
                       input logic [3:0] c, input logic [2:0] r);
    @(negedge clk);
    req_store = st; req_base = b; req_stride = s; req_count = c; req_reg = r;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_base = '0;
    req_stride = '0; req_count = '0; req_reg = '0;
    repeat (3) @(negedge clk);
    checks++; if ({req_ready, done, err} !== 3'b100) $display("FAIL reset_flags: got %b want 100", {req_ready, done, err}); else passes++;
    checks++; if ({mem_we, mem_re, rf_we} !== 3'b000) $display("FAIL reset_strobes: got %b want 000", {mem_we, mem_re, rf_we}); else passes++;
    checks++; if ({mem_addr, mem_wdata, rf_wdata} !== '0 || {rf_raddr, rf_waddr} !== 6'd0)
      $display("FAIL reset_data: addr %h wdata %h rfwdata %h want 0", mem_addr, mem_wdata, rf_wdata); else passes++;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", req_ready); else passes++;
  endtask

  task automatic test_load();
    logic [7:0] ea [3];
    logic [2:0] er [3];
    ea = '{8'd4, 8'd5, 8'd6};
    er = '{3'd2, 3'd3, 3'd4};
    issue(1'b0, 8'd4, 8'd1, 4'd3, 3'd2);
    for (int k = 0; k < 3; k++) begin
      checks++; if ({mem_we, mem_re, rf_we, req_ready} !== 4'b0110) $display("FAIL load_strobes[%0d]: got %b want 0110", k, {mem_we, mem_re, rf_we, req_ready}); else passes++;
      checks++; if (mem_addr !== {120'd0, ea[k]} || rf_waddr !== er[k]) $display("FAIL load_addr[%0d]: addr %0d reg %0d want %0d %0d", k, mem_addr, rf_waddr, ea[k], er[k]); else passes++;
      checks++; if (rf_wdata !== mem_pat(ea[k])) $display("FAIL load_data[%0d]: got %h want %h", k, rf_wdata, mem_pat(ea[k])); else passes++;
      @(negedge clk);
    end
    checks++; if ({done, err, mem_re, rf_we} !== 4'b1000) $display("FAIL load_done: got %b want 1000", {done, err, mem_re, rf_we}); else passes++;
    @(negedge clk);
    checks++; if ({done, req_ready} !== 2'b01) $display("FAIL load_idle: got %b want 01", {done, req_ready}); else passes++;
  endtask

  task automatic test_store();
    issue(1'b1, 8'd10, 8'd2, 4'd2, 3'd7);
    checks++; if ({mem_we, mem_re, rf_we} !== 3'b100) $display("FAIL store_strobes0: got %b want 100", {mem_we, mem_re, rf_we}); else passes++;
    checks++; if (mem_addr !== 128'd10 || rf_raddr !== 3'd7 || mem_wdata !== rf_pat(3'd7))
      $display("FAIL store_beat0: addr %0d reg %0d data %h want 10 7 %h", mem_addr, rf_raddr, mem_wdata, rf_pat(3'd7)); else passes++;
    @(negedge clk);
    checks++; if ({mem_we, mem_re, rf_we} !== 3'b100) $display("FAIL store_strobes1: got %b want 100", {mem_we, mem_re, rf_we}); else passes++;
    checks++; if (mem_addr !== 128'd12 || rf_raddr !== 3'd0 || mem_wdata !== rf_pat(3'd0))
      $display("FAIL store_beat1: addr %0d reg %0d data %h want 12 0 %h", mem_addr, rf_raddr, mem_wdata, rf_pat(3'd0)); else passes++;
    @(negedge clk);
    checks++; if ({done, err, mem_we} !== 3'b100) $display("FAIL store_done: got %b want 100", {done, err, mem_we}); else passes++;
  endtask

  task automatic test_out_of_range();
    issue(1'b0, 8'd127, 8'd1, 4'd3, 3'd0);
    checks++; if ({mem_re, rf_we, mem_addr[7:0], rf_waddr} !== {2'b11, 8'd127, 3'd0}) $display("FAIL oor_beat0: got %b/%0d/%0d want 11/127/0", {mem_re, rf_we}, mem_addr, rf_waddr); else passes++;
    @(negedge clk);
    checks++; if ({mem_re, rf_we, mem_addr[7:0], rf_waddr} !== {2'b11, 8'd128, 3'd1}) $display("FAIL oor_beat1: got %b/%0d/%0d want 11/128/1", {mem_re, rf_we}, mem_addr, rf_waddr); else passes++;
    @(negedge clk);
    checks++; if ({mem_we, mem_re, rf_we} !== 3'b000 || mem_addr !== 128'd129) $display("FAIL oor_beat2: got %b addr %0d want 000 129", {mem_we, mem_re, rf_we}, mem_addr); else passes++;
    @(negedge clk);
    checks++; if ({done, err} !== 2'b11) $display("FAIL oor_done: got %b want 11", {done, err}); else passes++;
  endtask

  task automatic test_wrap();
    issue(1'b1, 8'd250, 8'd4, 4'd2, 3'd0);
    checks++; if ({mem_we, mem_re, rf_we} !== 3'b000 || mem_addr !== 128'd250) $display("FAIL wrap_beat0: got %b addr %0d want 000 250", {mem_we, mem_re, rf_we}, mem_addr); else passes++;
    @(negedge clk);
    checks++; if ({mem_we, mem_re, rf_we} !== 3'b000 || mem_addr !== 128'd254) $display("FAIL wrap_beat1: got %b addr %0d want 000 254", {mem_we, mem_re, rf_we}, mem_addr); else passes++;
    @(negedge clk);
    checks++; if ({done, err} !== 2'b11) $display("FAIL wrap_done: got %b want 11", {done, err}); else passes++;
    // 252 + 8 wraps to 4, which is a legal address.
    issue(1'b0, 8'd252, 8'd8, 4'd2, 3'd3);
    checks++; if ({mem_re, rf_we} !== 2'b00 || mem_addr !== 128'd252) $display("FAIL wrap2_beat0: got %b addr %0d want 00 252", {mem_re, rf_we}, mem_addr); else passes++;
    @(negedge clk);
    checks++; if ({mem_re, rf_we} !== 2'b11 || mem_addr !== 128'd4 || rf_waddr !== 3'd4 || rf_wdata !== mem_pat(8'd4))
      $display("FAIL wrap2_beat1: got %b addr %0d reg %0d data %h want 11 4 4 %h", {mem_re, rf_we}, mem_addr, rf_waddr, rf_wdata, mem_pat(8'd4)); else passes++;
    @(negedge clk);
    checks++; if ({done, err} !== 2'b11) $display("FAIL wrap2_done: got %b want 11", {done, err}); else passes++;
  endtask

  task automatic test_count_edge();
    issue(1'b0, 8'd0, 8'd1, 4'd0, 3'd0);
    checks++; if ({done, err, mem_we, mem_re, rf_we} !== 5'b10000) $display("FAIL count0: got %b want 10000", {done, err, mem_we, mem_re, rf_we}); else passes++;
    @(negedge clk);
    checks++; if ({done, req_ready} !== 2'b01) $display("FAIL count0_idle: got %b want 01", {done, req_ready}); else passes++;
    issue(1'b1, 8'd0, 8'd1, 4'd9, 3'd0);
    checks++; if ({done, err, mem_we, mem_re, rf_we} !== 5'b11000) $display("FAIL count9: got %b want 11000", {done, err, mem_we, mem_re, rf_we}); else passes++;
  endtask

  task automatic test_back_to_back();
    // Fault from the previous request must clear on this accept.
    issue(1'b0, 8'd5, 8'd3, 4'd1, 3'd6);
    checks++; if ({mem_re, rf_we, mem_addr[7:0], rf_waddr} !== {2'b11, 8'd5, 3'd6}) $display("FAIL b2b_beat: got %b/%0d/%0d want 11/5/6", {mem_re, rf_we}, mem_addr, rf_waddr); else passes++;
    req_store = 1'b1; req_base = 8'd20; req_stride = 8'd1; req_count = 4'd1; req_reg = 3'd1;
    req_valid = 1'b1;
    @(negedge clk);
    checks++; if ({done, err, req_ready} !== 3'b100) $display("FAIL b2b_done: got %b want 100", {done, err, req_ready}); else passes++;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) $display("FAIL b2b_gap: got %b want 1", req_ready); else passes++;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if ({mem_we, mem_addr[7:0], rf_raddr, mem_wdata} !== {1'b1, 8'd20, 3'd1, rf_pat(3'd1)})
      $display("FAIL b2b_store: we %b addr %0d reg %0d want 1 20 1", mem_we, mem_addr, rf_raddr); else passes++;
    @(negedge clk);
    checks++; if ({done, err} !== 2'b10) $display("FAIL b2b_done2: got %b want 10", {done, err}); else passes++;
  endtask

  task automatic test_reset_mid_run();
    logic bad;
    issue(1'b0, 8'd0, 8'd1, 4'd4, 3'd0);
    checks++; if ({mem_re, rf_we} !== 2'b11) $display("FAIL rmr_beat0: got %b want 11", {mem_re, rf_we}); else passes++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({mem_we, mem_re, rf_we, done} !== 4'b0000) $display("FAIL rmr_gate: got %b want 0000", {mem_we, mem_re, rf_we, done}); else passes++;
    @(negedge clk);
    checks++; if ({req_ready, mem_re, rf_we, done} !== 4'b1000 || mem_addr !== '0) $display("FAIL rmr_idle: got %b addr %0d want 1000 0", {req_ready, mem_re, rf_we, done}, mem_addr); else passes++;
    rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || rf_we || mem_re || mem_we || !req_ready) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) $display("FAIL rmr_quiet: activity after reset, got 1 want 0"); else passes++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_out_of_range();
    test_wrap();
    test_count_edge();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dmem_lsu_seq.md
DMEM_LSU_SEQ -- requirements
Module: dmem_lsu_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 129, number of 128-bit data-memory words.
REQ-002 SHALL have parameter MAXB, default 8, maximum beats per request; register index width 3.
REQ-003 clk  in  1  clock, all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  1  core request present.
REQ-006 req_ready  out  1  sequencer can accept a request.
REQ-007 req_store  in  1  1 = store (regfile to memory), 0 = load (memory to regfile).
REQ-008 req_base  in  8  first memory word address.
REQ-009 req_stride  in  8  unsigned word-address increment per beat.
REQ-010 req_count  in  4  beat count, legal range 0..MAXB.
REQ-011 req_reg  in  3  first vector register index.
REQ-012 mem_addr  out  128  data-memory address, zero-extended from 8 bits.
REQ-013 mem_wdata  out  128  data-memory write data.
REQ-014 mem_we, mem_re  out  1 each  data-memory write and read enables.
REQ-015 mem_rdata  in  128  data-memory read data, combinational from mem_addr and mem_re.
REQ-016 rf_raddr  out  3 / rf_rdata  in  128  regfile read port, combinational.
REQ-017 rf_waddr  out  3 / rf_wdata  out  128 / rf_we  out  1  regfile write port.
REQ-018 done  out  1  one-cycle completion pulse / err  out  1  address-fault flag, valid while done=1.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, and DONE.
REQ-020 IDLE: req_ready=1; on req_valid&req_ready, latch all req_* fields; count 0 or count>MAXB goes to DONE, else goes to RUN.
REQ-021 RUN: exactly one beat per cycle; beat k uses address (req_base + k*req_stride) mod 256 and register (req_reg + k) mod 8.
REQ-022 Address arithmetic SHALL be 8-bit with wrap-around; there is no carry into bit 8.
REQ-023 A beat whose address is >= DEPTH SHALL assert neither mem_we/mem_re nor rf_we, and SHALL set the sticky fault bit.
REQ-024 Store beat: rf_raddr = beat register, mem_wdata = rf_rdata, mem_we=1, mem_re=0, all in the same cycle.
REQ-025 Load beat: mem_re=1, mem_we=0, rf_we=1, rf_waddr = beat register, rf_wdata = mem_rdata, all in the same cycle.
REQ-026 After the last beat the FSM SHALL move to DONE; a request of N beats occupies exactly N RUN cycles.
REQ-027 DONE: done=1 for one cycle; err = sticky fault bit, or 1 if count>MAXB; then return to IDLE; the fault bit SHALL clear on the next accept.
REQ-028 req_ready SHALL be 0 in RUN and DONE; req_valid is ignored there; back-to-back requests have a 1-cycle IDLE gap minimum.
REQ-029 Outside RUN: mem_we=mem_re=rf_we=0, mem_addr=0, mem_wdata=0.
REQ-030 mem_we and mem_re SHALL never both be 1.

Reset
REQ-031 While rst=0 at a posedge: state becomes IDLE; beat counter, fault bit, and latched fields become 0.
REQ-032 mem_we, mem_re, rf_we, and done SHALL be gated to 0 combinationally while rst=0, including mid-RUN, so no partial beat is written.
REQ-033 After reset: req_ready=1, done=0, err=0, and all address/data outputs are 0.

Structure
REQ-034 A shared package SHALL hold the DEPTH and MAXB defaults, the 8-bit address width, and the state encoding (IDLE=0, RUN=1, DONE=2).
REQ-035 One sub-module, lsu_addr_gen, SHALL be provided: latched base and stride, beat counter, current address, register index, in-range and last-beat flags.

Verification
REQ-036 Load: base=4, stride=1, count=3, reg=2, memory[4..6]=A,B,C -> rf writes r2=A, r3=B, r4=C on 3 consecutive cycles, then done=1, err=0.
REQ-037 Store: base=10, stride=2, count=2, reg=7, r7=X, r0=Y -> mem[10]=X, mem[12]=Y (register wraps 7 to 0), done, err=0.
REQ-038 Out of range: base=127, stride=1, count=3, load -> beats at 127 and 128 are performed, beat at 129 is suppressed, done with err=1.
REQ-039 Wrap-around: base=250, stride=4, count=2 -> addresses 250 (fault) and 254 (fault), no memory access, err=1.
REQ-040 Count 0 -> done the cycle after accept, no access, err=0; count=9 -> done, err=1, no access.
REQ-041 Reset mid-RUN after beat 1 of 4 -> no further we/re/rf_we, IDLE with req_ready=1 next cycle, done never pulses.
